// File: rtl/usb_tx_pkg.sv
// usb_tx_pkg: shared types and default timing parameters for the USB TX bit timer
package usb_tx_pkg;
    typedef enum logic {TXT_IDLE, TXT_RUN} tx_timer_state_t;
    localparam int TX_BASE_PERIOD_DEF = 8;
    localparam int TX_LONG_EVERY_DEF = 3;
endpackage

// File: rtl/flex_counter.sv
// flex_counter: 0..rollover_val wrapping counter with a registered flag high while count equals rollover_val
module flex_counter #(
    parameter int NUM_CNT_BITS = 4
) (
    input  logic                    clk,
    input  logic                    n_rst,
    input  logic                    clear,
    input  logic                    count_enable,
    input  logic [NUM_CNT_BITS-1:0] rollover_val,
    output logic [NUM_CNT_BITS-1:0] count_out,
    output logic                    rollover_flag
);
    logic [NUM_CNT_BITS-1:0] next_count;

    always_comb
        next_count = clear ? '0 : !count_enable ? count_out :
                     count_out == rollover_val ? '0 : count_out + NUM_CNT_BITS'(1);

    // Flag is looked ahead from next_count so it is a clean flop output
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            count_out     <= '0;
            rollover_flag <= 1'b0;
        end else begin
            count_out     <= next_count;
            rollover_flag <= count_enable && !clear && next_count == rollover_val;
        end
    end
endmodule

// File: rtl/tx_bit_timer.sv
// tx_bit_timer: fractional bit-period timer emitting shift, byte and done strobes for a TX frame
module tx_bit_timer
    import usb_tx_pkg::*;
#(
    parameter int BASE_PERIOD = TX_BASE_PERIOD_DEF,
    parameter int LONG_EVERY  = TX_LONG_EVERY_DEF,
    parameter int LEN_W       = 10
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic             start,
    input  logic             abort,
    input  logic [LEN_W-1:0] num_bits,
    output logic             busy,
    output logic             shift_strobe,
    output logic             byte_done,
    output logic [LEN_W-1:0] bit_count,
    output logic             done
);
    localparam int CW = $clog2(BASE_PERIOD + 2);
    localparam int PW = $clog2(LONG_EVERY > 2 ? LONG_EVERY : 2);
    localparam logic [PW-1:0] PH_LAST = PW'(LONG_EVERY == 0 ? 0 : LONG_EVERY - 1);

    tx_timer_state_t state, state_n;
    logic [CW-1:0]    cnt, roll;
    logic [PW-1:0]    phase, phase_n;
    logic [LEN_W-1:0] len, len_n, bit_count_n;
    logic             run, accept, ending, done_n, byte_done_n;

    assign busy = state == TXT_RUN;

    // ending looks one clock ahead so done/byte_done line up with the registered strobe
    always_comb begin
        run         = busy;
        accept      = start && !abort && (!run || done);
        roll        = (LONG_EVERY != 0 && phase == PH_LAST) ? CW'(BASE_PERIOD) : CW'(BASE_PERIOD - 1);
        ending      = run && !abort && cnt == roll - CW'(1);
        state_n     = abort ? TXT_IDLE : accept ? (num_bits != '0 ? TXT_RUN : TXT_IDLE) :
                      (run && done) ? TXT_IDLE : state;
        len_n       = accept ? num_bits : len;
        phase_n     = (abort || accept) ? '0 : (run && shift_strobe) ?
                      (phase == PH_LAST ? '0 : phase + PW'(1)) : phase;
        bit_count_n = (abort || accept) ? '0 : (run && shift_strobe) ? bit_count + LEN_W'(1) : bit_count;
        done_n      = !abort && (accept ? num_bits == '0 : ending && bit_count == len - LEN_W'(1));
        byte_done_n = ending && bit_count[2:0] == 3'b111;
    end

    flex_counter #(.NUM_CNT_BITS(CW)) u_clk_cnt (
        .clk          (clk),
        .n_rst        (n_rst),
        .clear        (abort || accept),
        .count_enable (run),
        .rollover_val (roll),
        .count_out    (cnt),
        .rollover_flag(shift_strobe)
    );

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state     <= TXT_IDLE;
            phase     <= '0;
            len       <= '0;
            bit_count <= '0;
            done      <= 1'b0;
            byte_done <= 1'b0;
        end else begin
            state     <= state_n;
            phase     <= phase_n;
            len       <= len_n;
            bit_count <= bit_count_n;
            done      <= done_n;
            byte_done <= byte_done_n;
        end
    end
endmodule

// File: tb/tb_tx_bit_timer.sv
// tb_tx_bit_timer: directed and randomized checks of tx_bit_timer against a closed-form frame model
module tb_tx_bit_timer;
    localparam int BP = 8, LE = 3, LW = 10;

    logic clk = 0, n_rst = 0, start = 0, abort = 0;
    logic [LW-1:0] num_bits = '0;
    logic busy, shift_strobe, byte_done, done;
    logic [LW-1:0] bit_count;
    int checks = 0, passed = 0;

    always #5 clk = ~clk;

    tx_bit_timer #(.BASE_PERIOD(BP), .LONG_EVERY(LE), .LEN_W(LW)) dut (
        .clk(clk), .n_rst(n_rst), .start(start), .abort(abort), .num_bits(num_bits),
        .busy(busy), .shift_strobe(shift_strobe), .byte_done(byte_done),
        .bit_count(bit_count), .done(done)
    );

    // Model: frame-relative cycle t (1 = first cycle after acceptance); bit i ends at bit_end(i)
    bit m_run = 0, m_zdone = 0;
    int m_t = 0, m_len = 0, m_idle_bc = 0;

    function automatic int bit_end(int i);
        return (i + 1) * BP + (LE != 0 ? (i + 1) / LE : 0);
    endfunction

    function automatic int bits_done(int t, int len);
        int k = 0;
        while (k < len && bit_end(k) < t) k++;
        return k;
    endfunction

    function automatic logic [13:0] expv();
        int bc;
        logic s;
        if (!m_run) return {3'b000, m_zdone, LW'(m_idle_bc)};
        bc = bits_done(m_t, m_len);
        s = bit_end(bc) == m_t;
        return {1'b1, s, s && bc % 8 == 7, s && bc == m_len - 1, LW'(bc)};
    endfunction

    function automatic bit fin();
        logic [13:0] e;
        e = expv();
        return e[10];
    endfunction

    always @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            m_run <= 0; m_t <= 0; m_len <= 0; m_idle_bc <= 0; m_zdone <= 0;
        end else if (abort) begin
            m_run <= 0; m_idle_bc <= 0; m_zdone <= 0;
        end else if (start && (!m_run || fin())) begin
            m_len <= int'(num_bits); m_idle_bc <= 0; m_t <= 1;
            m_run <= num_bits != '0; m_zdone <= num_bits == '0;
        end else if (m_run && fin()) begin
            m_run <= 0; m_idle_bc <= m_len; m_zdone <= 0;
        end else begin
            m_t <= m_t + 1; m_zdone <= 0;
        end
    end

    always @(negedge clk) begin
        logic [13:0] e, a;
        e = expv();
        a = {busy, shift_strobe, byte_done, done, bit_count};
        checks++;
        if (a === e) passed++;
        else $display("FAIL cycle_model t=%0t got busy/strb/byte/done/cnt=%b/%b/%b/%b/%0d want %b/%b/%b/%b/%0d",
                      $time, a[13], a[12], a[11], a[10], a[9:0], e[13], e[12], e[11], e[10], e[9:0]);
    end

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act == exp) passed++;
        else $display("FAIL %s got %0d want %0d", nm, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_frame(input int n, input int span, output int ns, output int nb,
                             output int first_s, output int last_s, output int done_t, output int busy_n);
        start = 1; num_bits = LW'(n);
        tick();
        start = 0; num_bits = LW'($urandom);
        ns = 0; nb = 0; first_s = -1; last_s = -1; done_t = -1; busy_n = 0;
        for (int t = 1; t <= span; t++) begin
            @(negedge clk);
            if (shift_strobe) begin
                ns++;
                if (first_s < 0) first_s = t;
                last_s = t;
                if (byte_done) nb++;
            end
            if (done) done_t = t;
            if (busy) busy_n++;
        end
    endtask

    initial begin
        int ns, nb, fs, ls, dt, bn, cnt;
        repeat (2) tick();
        chk("reset_outputs", int'({busy, shift_strobe, byte_done, done, bit_count}), 0);
        n_rst = 1;
        tick();
        run_frame(3, 30, ns, nb, fs, ls, dt, bn);
        chk("f3_first_strobe", fs, 8);
        chk("f3_last_strobe", ls, 25);
        chk("f3_strobes", ns, 3);
        chk("f3_done_cycle", dt, 25);
        chk("f3_busy_cycles", bn, 25);
        chk("f3_final_count", int'(bit_count), 3);
        chk("model_end2", bit_end(2), 25);
        chk("model_end15", bit_end(15), 133);
        run_frame(16, 140, ns, nb, fs, ls, dt, bn);
        chk("f16_strobes", ns, 16);
        chk("f16_bytes", nb, 2);
        chk("f16_last_strobe", ls, 133);
        chk("f16_done_cycle", dt, 133);
        run_frame(0, 10, ns, nb, fs, ls, dt, bn);
        chk("f0_done_cycle", dt, 1);
        chk("f0_busy_cycles", bn, 0);
        chk("f0_strobes", ns, 0);
        start = 1; num_bits = 10;
        tick();
        start = 0;
        repeat (11) tick();
        abort = 1;
        tick();
        abort = 0;
        chk("abort_busy", int'(busy), 0);
        chk("abort_count", int'(bit_count), 0);
        cnt = 0;
        repeat (20) begin @(negedge clk); if (done) cnt++; end
        chk("abort_no_done", cnt, 0);
        abort = 1; start = 1; num_bits = 5;
        tick();
        abort = 0; start = 0;
        cnt = 0;
        repeat (12) begin @(negedge clk); if (busy || shift_strobe || done) cnt++; end
        chk("abort_start_idle", cnt, 0);
        start = 1; num_bits = 2;
        tick();
        start = 0;
        repeat (15) tick();
        chk("b2b_final_strobe", int'(shift_strobe && done), 1);
        start = 1; num_bits = 2;
        tick();
        start = 0;
        cnt = 0; fs = -1;
        for (int t = 1; t <= 8; t++) begin
            @(negedge clk);
            if (busy) cnt++;
            if (shift_strobe && fs < 0) fs = t;
        end
        chk("b2b_busy_gapless", cnt, 8);
        chk("b2b_next_strobe", fs, 8);
        repeat (20) tick();
        start = 1; num_bits = 10;
        tick();
        start = 0;
        repeat (20) tick();
        #2 n_rst = 0;
        #1 chk("async_reset_outputs", int'({busy, shift_strobe, byte_done, done, bit_count}), 0);
        repeat (3) @(posedge clk);
        #1 n_rst = 1;
        tick();
        chk("post_reset_idle", int'(busy), 0);
        repeat (15000) begin
            start = ($urandom % 4) == 0;
            abort = ($urandom % 60) == 0;
            num_bits = ($urandom % 8 == 0) ? '0 : LW'($urandom_range(1, 24));
            tick();
        end
        start = 0; abort = 0;
        repeat (5) tick();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
